multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

- Sequencing controller for the multi-cycle core, the successor to the single-cycle datapath.
- Decodes the instruction held in the instruction register and walks a state machine that time-shares one ALU and one unified memory port.
- Adds a memory ready handshake for wait states, a sticky illegal-instruction trap, and a parametrised retired-instruction counter.
- Sits between the instruction register, the datapath muxes and the memory interface.

## Interface
Parameters:
- ALU_CTRL_W, 3: width of alu_control; must be ≥3; bits above [2] are driven 0.
- CNT_W, 32: width of retired_count; must be ≥1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  active-low reset, asserted asynchronously.
- op  in  7  instruction [6:0].
- funct3  in  3  instruction [14:12].
- funct7_5  in  1  instruction [30].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current read/write this cycle.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load the instruction register and OldPC.
- pc_write  out  1  load the PC from the result bus.
- reg_write  out  1  register file write enable.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4.
- result_src  out  2  result bus select: 00 = ALUOut, 01 = read data, 10 = live ALU result.
- imm_src  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- alu_control  out  ALU_CTRL_W  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- illegal  out  1  sticky trap flag.
- retired_count  out  CNT_W  count of completed instructions.
- state  out  4  current state, for debug.

## Operation
State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11.

Supported opcodes: lw 0000011, sw 0100011, R 0110011, I 0010011, beq 1100011, jal 1101111.

imm_src is decoded from op in every state: lw/I → 00, sw → 01, beq → 10, jal → 11, other → 00.

Per-state outputs. Any strobe not listed is 0; unlisted selects are don't-care but held at 00.
- FETCH: mem_read=1, adr_src=0, alu_src_a=00, alu_src_b=10, add, result_src=10, ir_write=pc_write=mem_ready. Stay in FETCH while mem_ready=0; on mem_ready=1 → DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, add (branch target into ALUOut).
  - lw/sw → MEMADR.
  - R → EXECR.
  - I → EXECI.
  - beq → BEQ.
  - jal → JAL.
  - Unlisted op → TRAP.
  - R or I with funct3 ∉ {000, 010, 110, 111} → TRAP.
- MEMADR: alu_src_a=10, alu_src_b=01, add. lw → MEMREAD, sw → MEMWRITE.
- MEMREAD: mem_read=1, adr_src=1. Wait for mem_ready, then → MEMWB.
- MEMWB: result_src=01, reg_write=1 → FETCH.
- MEMWRITE: mem_write=1, adr_src=1. Wait for mem_ready, then → FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, funct decode → ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, funct decode → ALUWB.
- ALUWB: result_src=00, reg_write=1 → FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00, pc_write=zero → FETCH.
- JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1 → ALUWB.
- TRAP: all strobes 0, illegal=1. Absorbing; only reset exits.

Funct decode:
- funct3 000 → sub if R and funct7_5=1, else add. I-type ignores funct7_5.
- funct3 010 → slt.
- funct3 110 → or.
- funct3 111 → and.

Retired counter:
- Increments by 1 on leaving MEMWB, ALUWB, BEQ, or MEMWRITE (the MEMWRITE exit only when mem_ready=1).
- jal counts once, at its ALUWB.
- Wraps from 2^CNT_W−1 to 0.
- Frozen in TRAP.

## Timing
- Reset values: state=FETCH, illegal=0, retired_count=0.
- While rst=0: mem_read, mem_write, ir_write, pc_write and reg_write are forced to 0 irrespective of mem_ready.
- Reset deasserting mid-instruction discards the instruction; execution restarts at FETCH.
- Outputs are Moore, except ir_write/pc_write in FETCH (gated combinationally by mem_ready) and pc_write in BEQ (gated by zero).
- Zero-wait latency in cycles: lw 5; sw, R, I and jal 4; beq 3.
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- The request (mem_read/mem_write) and adr_src are held stable until mem_ready is sampled high.
- mem_ready is ignored in every other state.

## Test plan
- Reset with mem_ready=1 held high: all strobes 0 during reset. After release, state=0, mem_read=1, and pc_write=ir_write=1 in the first cycle.
- add (op 0110011, funct3 000, funct7_5 0), then sub (funct7_5 1), mem_ready=1: state sequence 0,1,6,8,0; alu_control 000 then 001 in EXECR; reg_write only in ALUWB; retired_count 0→2.
- lw with mem_ready low for 3 cycles in MEMREAD: state sequence 0,1,2,3,3,3,3,4,0; adr_src=1 throughout MEMREAD; reg_write with result_src=01 in MEMWB.
- beq: zero=1 → pc_write=1 in BEQ; zero=0 → pc_write=0. retired_count increments in both cases; 3 cycles each.
- jal: state sequence 0,1,10,8,0; imm_src=11; JAL drives pc_write=1, alu_src_a=01, alu_src_b=10; retired_count +1 total.
- Illegal op 1111111 and R-type funct3 001: each goes DECODE → TRAP with illegal=1 held. No strobes for 10 cycles; retired_count frozen; reset clears illegal.
- CNT_W=2: five retired instructions give counts 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Sequencing FSM for the multi-cycle core: one ALU, one unified memory
// port, mem_ready wait states, sticky illegal trap, retired counter.
module multicycle_control_unit #(
  parameter int ALU_CTRL_W = 3,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7_5,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  adr_src,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  reg_write,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            result_src,
  output logic [1:0]            imm_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  illegal,
  output logic [CNT_W-1:0]      retired_count,
  output logic [3:0]            state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       adr_src;
    logic       fetch;
    logic       reg_write;
    logic       pc_jump;
    logic       pc_branch;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] res;
    logic [2:0] alu;
  } ctrl_t;

  state_t           cur;
  state_t           nxt;
  ctrl_t            ctrl;
  logic             trap_q;
  logic [CNT_W-1:0] count;
  logic             retire;
  logic [2:0]       funct_alu;
  logic             f3_ok;
  logic             is_lw;
  logic             is_sw;
  logic             is_r;
  logic             is_i;
  logic             is_beq;
  logic             is_jal;

  assign is_lw  = (op == OP_LW);
  assign is_sw  = (op == OP_SW);
  assign is_r   = (op == OP_R);
  assign is_i   = (op == OP_I);
  assign is_beq = (op == OP_BEQ);
  assign is_jal = (op == OP_JAL);

  assign f3_ok = (funct3 == 3'b000) | (funct3 == 3'b010)
               | (funct3 == 3'b110) | (funct3 == 3'b111);

  always_comb begin
    funct_alu = ALU_ADD;
    unique case (funct3)
      3'b000:  funct_alu = (is_r & funct7_5) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_alu = ALU_SLT;
      3'b110:  funct_alu = ALU_OR;
      3'b111:  funct_alu = ALU_AND;
      default: funct_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    nxt = cur;
    unique case (cur)
      S_FETCH:  if (mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_lw | is_sw: nxt = S_MEMADR;
          is_r & f3_ok:  nxt = S_EXECR;
          is_i & f3_ok:  nxt = S_EXECI;
          is_beq:        nxt = S_BEQ;
          is_jal:        nxt = S_JAL;
          default:       nxt = S_TRAP;
        endcase
      end
      S_MEMADR:   nxt = is_lw ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) nxt = S_MEMWB;
      S_MEMWB:    nxt = S_FETCH;
      S_MEMWRITE: if (mem_ready) nxt = S_FETCH;
      S_EXECR:    nxt = S_ALUWB;
      S_EXECI:    nxt = S_ALUWB;
      S_ALUWB:    nxt = S_FETCH;
      S_BEQ:      nxt = S_FETCH;
      S_JAL:      nxt = S_ALUWB;
      S_TRAP:     nxt = S_TRAP;
      default:    nxt = S_FETCH;
    endcase
  end

  // Control word for the state being entered, so outputs come from flops.
  function automatic ctrl_t ctrl_of(input state_t s, input logic [2:0] fa);
    ctrl_t c;
    c = '0;
    unique case (s)
      S_FETCH: begin
        c.mem_read = 1'b1;
        c.fetch    = 1'b1;
        c.src_b    = 2'b10;
        c.res      = 2'b10;
      end
      S_DECODE: begin
        c.src_a = 2'b01;
        c.src_b = 2'b01;
      end
      S_MEMADR: begin
        c.src_a = 2'b10;
        c.src_b = 2'b01;
      end
      S_MEMREAD: begin
        c.mem_read = 1'b1;
        c.adr_src  = 1'b1;
      end
      S_MEMWB: begin
        c.res       = 2'b01;
        c.reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        c.mem_write = 1'b1;
        c.adr_src   = 1'b1;
      end
      S_EXECR: begin
        c.src_a = 2'b10;
        c.alu   = fa;
      end
      S_EXECI: begin
        c.src_a = 2'b10;
        c.src_b = 2'b01;
        c.alu   = fa;
      end
      S_ALUWB: c.reg_write = 1'b1;
      S_BEQ: begin
        c.src_a     = 2'b10;
        c.alu       = ALU_SUB;
        c.pc_branch = 1'b1;
      end
      S_JAL: begin
        c.src_a   = 2'b01;
        c.src_b   = 2'b10;
        c.pc_jump = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign retire = (cur == S_MEMWB) | (cur == S_ALUWB) | (cur == S_BEQ)
                | ((cur == S_MEMWRITE) & mem_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur    <= S_FETCH;
      ctrl   <= ctrl_of(S_FETCH, ALU_ADD);
      trap_q <= 1'b0;
      count  <= '0;
    end else begin
      cur  <= nxt;
      ctrl <= ctrl_of(nxt, funct_alu);
      if (nxt == S_TRAP) trap_q <= 1'b1;
      if (retire) count <= count + CNT_W'(1);
    end
  end

  always_comb begin
    imm_src = 2'b00;
    unique case (1'b1)
      is_sw:   imm_src = 2'b01;
      is_beq:  imm_src = 2'b10;
      is_jal:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  assign mem_read  = rst & ctrl.mem_read;
  assign mem_write = rst & ctrl.mem_write;
  assign reg_write = rst & ctrl.reg_write;
  assign ir_write  = rst & ctrl.fetch & mem_ready;
  assign pc_write  = rst & ((ctrl.fetch & mem_ready) | ctrl.pc_jump
                   | (ctrl.pc_branch & zero));

  assign adr_src       = ctrl.adr_src;
  assign alu_src_a     = ctrl.src_a;
  assign alu_src_b     = ctrl.src_b;
  assign result_src    = ctrl.res;
  assign alu_control   = ALU_CTRL_W'(ctrl.alu);
  assign illegal       = trap_q;
  assign retired_count = count;
  assign state         = cur;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: vector table, hand sequences,
// and random instruction streams against a path-queue reference model.
module tb_multicycle_control_unit;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic        clk;
  logic        rst;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        zero;
  logic        mem_ready;
  logic        mem_read;
  logic        mem_write;
  logic        adr_src;
  logic        ir_write;
  logic        pc_write;
  logic        reg_write;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  result_src;
  logic [1:0]  imm_src;
  logic [2:0]  alu_control;
  logic        illegal;
  logic [31:0] retired_count;
  logic [3:0]  state;

  logic        d2_mem_read;
  logic        d2_mem_write;
  logic        d2_adr_src;
  logic        d2_ir_write;
  logic        d2_pc_write;
  logic        d2_reg_write;
  logic [1:0]  d2_alu_src_a;
  logic [1:0]  d2_alu_src_b;
  logic [1:0]  d2_result_src;
  logic [1:0]  d2_imm_src;
  logic [3:0]  d2_alu_control;
  logic        d2_illegal;
  logic [1:0]  d2_retired_count;
  logic [3:0]  d2_state;

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3),
    .funct7_5(funct7_5), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .imm_src(imm_src),
    .alu_control(alu_control), .illegal(illegal),
    .retired_count(retired_count), .state(state)
  );

  multicycle_control_unit #(.ALU_CTRL_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3),
    .funct7_5(funct7_5), .zero(zero), .mem_ready(mem_ready),
    .mem_read(d2_mem_read), .mem_write(d2_mem_write),
    .adr_src(d2_adr_src), .ir_write(d2_ir_write),
    .pc_write(d2_pc_write), .reg_write(d2_reg_write),
    .alu_src_a(d2_alu_src_a), .alu_src_b(d2_alu_src_b),
    .result_src(d2_result_src), .imm_src(d2_imm_src),
    .alu_control(d2_alu_control), .illegal(d2_illegal),
    .retired_count(d2_retired_count), .state(d2_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int q[$];
  logic [31:0] m_count = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] funct_op(input logic [2:0] f3,
                                          input logic f7, input bit isr);
    case (f3)
      3'b000:  return (isr && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // {mem_read,mem_write,adr_src,ir_write,pc_write,reg_write,
  //  src_a,src_b,result_src,imm_src,alu_control,illegal}
  function automatic logic [17:0] exp_out(input int s, input bit rv,
      input bit rdy, input bit z, input logic [6:0] o,
      input logic [2:0] f3, input logic f7);
    bit mr, mw, adr, ir, pc, rw;
    logic [1:0] a, b, res, imm;
    logic [2:0] alu;
    mr = 0; mw = 0; adr = 0; ir = 0; pc = 0; rw = 0;
    a = 2'd0; b = 2'd0; res = 2'd0; alu = 3'd0;
    case (s)
      0: begin mr = 1; b = 2'd2; res = 2'd2; ir = rdy; pc = rdy; end
      1: begin a = 2'd1; b = 2'd1; end
      2: begin a = 2'd2; b = 2'd1; end
      3: begin mr = 1; adr = 1; end
      4: begin res = 2'd1; rw = 1; end
      5: begin mw = 1; adr = 1; end
      6: begin a = 2'd2; alu = funct_op(f3, f7, 1'b1); end
      7: begin a = 2'd2; b = 2'd1; alu = funct_op(f3, f7, 1'b0); end
      8: rw = 1;
      9: begin a = 2'd2; alu = 3'd1; pc = z; end
      10: begin a = 2'd1; b = 2'd2; pc = 1; end
      default: ;
    endcase
    if (!rv) begin
      mr = 0; mw = 0; ir = 0; pc = 0; rw = 0;
    end
    if (o == OP_SW) imm = 2'd1;
    else if (o == OP_BEQ) imm = 2'd2;
    else if (o == OP_JAL) imm = 2'd3;
    else imm = 2'd0;
    return {mr, mw, adr, ir, pc, rw, a, b, res, imm, alu, (s == 11)};
  endfunction

  function automatic logic [17:0] act_out();
    return {mem_read, mem_write, adr_src, ir_write, pc_write, reg_write,
            alu_src_a, alu_src_b, result_src, imm_src, alu_control,
            illegal};
  endfunction

  task automatic check_cycle(input string nm, input int s);
    chk({nm, "_state"}, 64'(state), 64'(s));
    chk({nm, "_out"}, 64'(act_out()),
        64'(exp_out(s, rst, mem_ready, zero, op, funct3, funct7_5)));
    chk({nm, "_count"}, 64'(retired_count), 64'(m_count));
    chk({nm, "_cnt2"}, 64'(d2_retired_count), 64'(m_count[1:0]));
    chk({nm, "_alu_hi"}, 64'(d2_alu_control[3]), 64'(0));
  endtask

  // Entered and left at posedge+1; reset asserted asynchronously.
  task automatic do_reset();
    rst = 1'b0;
    mem_ready = 1'b1;
    #2;
    chk("rst_state", 64'(state), 64'(0));
    chk("rst_out", 64'(act_out()),
        64'(exp_out(0, 1'b0, 1'b1, zero, op, funct3, funct7_5)));
    chk("rst_count", 64'(retired_count), 64'(0));
    @(posedge clk);
    #1;
    chk("rst_hold", 64'(act_out()),
        64'(exp_out(0, 1'b0, 1'b1, zero, op, funct3, funct7_5)));
    rst = 1'b1;
    q.delete();
    m_count = 0;
  endtask

  function automatic bit f3_legal(input logic [2:0] f);
    return (f == 3'b000) || (f == 3'b010) || (f == 3'b110) || (f == 3'b111);
  endfunction

  function automatic logic [2:0] pick_f3();
    case ($urandom_range(0, 3))
      0: return 3'b000;
      1: return 3'b010;
      2: return 3'b110;
      default: return 3'b111;
    endcase
  endfunction

  task automatic new_instr();
    int k;
    k = $urandom_range(0, 9);
    funct3 = 3'($urandom);
    funct7_5 = 1'($urandom);
    case (k)
      0: op = OP_LW;
      1: op = OP_SW;
      2, 9: begin op = OP_R; funct3 = pick_f3(); end
      3: begin op = OP_I; funct3 = pick_f3(); end
      4: op = OP_BEQ;
      5: op = OP_JAL;
      6: op = OP_R;
      7: op = OP_I;
      default: op = ($urandom_range(0, 3) == 0) ? 7'($urandom) : OP_LW;
    endcase
    q.delete();
    q.push_back(0);
    q.push_back(1);
    if (op == OP_LW) begin
      q.push_back(2); q.push_back(3); q.push_back(4);
    end else if (op == OP_SW) begin
      q.push_back(2); q.push_back(5);
    end else if (op == OP_R && f3_legal(funct3)) begin
      q.push_back(6); q.push_back(8);
    end else if (op == OP_I && f3_legal(funct3)) begin
      q.push_back(7); q.push_back(8);
    end else if (op == OP_BEQ) begin
      q.push_back(9);
    end else if (op == OP_JAL) begin
      q.push_back(10); q.push_back(8);
    end else begin
      q.push_back(11);
    end
  endtask

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    int          waits;
    int          len;
    logic [39:0] seq;
    logic [2:0]  alu;
    int          retire;
  } vec_t;

  vec_t vt[$];

  task automatic add_vec(input string n, input logic [6:0] o,
      input logic [2:0] f3, input logic f7, input logic z, input int w,
      input int len, input logic [39:0] seq, input logic [2:0] alu,
      input int ret);
    vec_t v;
    v.name = n; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z;
    v.waits = w; v.len = len; v.seq = seq; v.alu = alu; v.retire = ret;
    vt.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    int w;
    logic [3:0] es;
    do_reset();
    op = v.op; funct3 = v.f3; funct7_5 = v.f7; zero = v.z;
    w = 0;
    for (int i = 0; i < v.len; i++) begin
      es = v.seq[39 - 4*i -: 4];
      mem_ready = 1'b1;
      if ((es == 4'd3 || es == 4'd5) && w < v.waits) begin
        mem_ready = 1'b0;
        w++;
      end
      #3;
      chk({v.name, "_seq"}, 64'(state), 64'(es));
      chk({v.name, "_out"}, 64'(act_out()),
          64'(exp_out(int'(es), 1'b1, mem_ready, zero, op, funct3,
                      funct7_5)));
      if (i == 2) chk({v.name, "_alu"}, 64'(alu_control), 64'(v.alu));
      @(posedge clk);
      #1;
    end
    chk({v.name, "_retired"}, 64'(retired_count), 64'(v.retire));
  endtask

  int c2 [5] = '{1, 2, 3, 0, 1};

  initial begin
    int cur;
    int trap_cycles;
    rst = 1'b1; op = OP_R; funct3 = 3'b000; funct7_5 = 1'b0;
    zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;

    add_vec("add",  OP_R,   3'b000, 1'b0, 1'b0, 0, 5, 40'h01680FFFFF, 3'b000, 1);
    add_vec("sub",  OP_R,   3'b000, 1'b1, 1'b0, 0, 5, 40'h01680FFFFF, 3'b001, 1);
    add_vec("addi", OP_I,   3'b000, 1'b1, 1'b0, 0, 5, 40'h01780FFFFF, 3'b000, 1);
    add_vec("slt",  OP_R,   3'b010, 1'b0, 1'b0, 0, 5, 40'h01680FFFFF, 3'b101, 1);
    add_vec("ori",  OP_I,   3'b110, 1'b0, 1'b0, 0, 5, 40'h01780FFFFF, 3'b011, 1);
    add_vec("and",  OP_R,   3'b111, 1'b1, 1'b0, 0, 5, 40'h01680FFFFF, 3'b010, 1);
    add_vec("lw3",  OP_LW,  3'b010, 1'b0, 1'b0, 3, 9, 40'h012333340F, 3'b000, 1);
    add_vec("sw2",  OP_SW,  3'b010, 1'b0, 1'b0, 2, 7, 40'h0125550FFF, 3'b000, 1);
    add_vec("beqt", OP_BEQ, 3'b000, 1'b0, 1'b1, 0, 4, 40'h0190FFFFFF, 3'b001, 1);
    add_vec("beqn", OP_BEQ, 3'b000, 1'b0, 1'b0, 0, 4, 40'h0190FFFFFF, 3'b001, 1);
    add_vec("jal",  OP_JAL, 3'b000, 1'b0, 1'b0, 0, 5, 40'h01A80FFFFF, 3'b000, 1);
    add_vec("bad",  7'h7F,  3'b000, 1'b0, 1'b0, 0, 10, 40'h01BBBBBBBB, 3'b000, 0);
    add_vec("rf1",  OP_R,   3'b001, 1'b0, 1'b0, 0, 10, 40'h01BBBBBBBB, 3'b000, 0);
    add_vec("if4",  OP_I,   3'b100, 1'b0, 1'b0, 0, 10, 40'h01BBBBBBBB, 3'b000, 0);

    foreach (vt[i]) run_vec(vt[i]);

    // Reset clears the sticky trap.
    do_reset();
    #3;
    chk("trap_cleared", 64'(illegal), 64'(0));
    chk("rel_ir", 64'(ir_write), 64'(1));
    chk("rel_pc", 64'(pc_write), 64'(1));
    chk("rel_rd", 64'(mem_read), 64'(1));
    @(posedge clk);
    #1;

    // Narrow counter wraps.
    do_reset();
    op = OP_R; funct3 = 3'b000; funct7_5 = 1'b0; mem_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      repeat (4) @(posedge clk);
      #1;
      chk("cnt2_wrap", 64'(d2_retired_count), 64'(c2[n]));
    end

    // Reset mid-lw discards it.
    do_reset();
    op = OP_LW; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_memadr", 64'(state), 64'(2));
    rst = 1'b0;
    #1;
    chk("mid_rst_state", 64'(state), 64'(0));
    chk("mid_rst_rd", 64'(mem_read), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    #3;
    chk("mid_restart", 64'(state), 64'(0));
    repeat (5) @(posedge clk);
    #1;
    chk("mid_done_state", 64'(state), 64'(0));
    chk("mid_done_count", 64'(retired_count), 64'(1));

    // Random instruction stream with wait states and resets.
    do_reset();
    trap_cycles = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 299) == 0 || trap_cycles > 12) begin
        do_reset();
        trap_cycles = 0;
      end
      if (q.size() == 0) new_instr();
      mem_ready = ($urandom_range(0, 3) != 0);
      zero = 1'($urandom);
      #3;
      check_cycle("rand", q[0]);
      @(posedge clk);
      cur = q[0];
      if (cur == 11) begin
        trap_cycles++;
      end else if ((cur == 0 || cur == 3 || cur == 5) && !mem_ready) begin
        trap_cycles = 0;
      end else begin
        void'(q.pop_front());
        if (q.size() == 0) m_count++;
      end
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
